fpu_addsub_seq: RTL and testbench

- Multi-cycle sequencer for the 8-bit floating-point add/subtract datapath.
- Accepts one operand pair plus an op select through a valid/ready handshake, then steps through compare/swap, alignment, add/sub, normalization and rounding, one micro-step per cycle.
- Presents the result through a valid/ready output handshake.
- Sits between the FPU issue logic and the result writeback.

---
 rtl/fpu_addsub_seq_pkg.sv | 30 +++
 rtl/fpu_addsub_seq_if.sv | 45 ++++
 rtl/fpu_round_rne.sv | 25 ++
 rtl/fpu_addsub_seq.sv | 211 +++++++++++++++++++++
 tb/tb_fpu_addsub_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_addsub_seq_pkg.sv
// fpu_pkg: shared types and constants for the 8-bit floating-point
// add/subtract sequencer.
//   fp8_t       : {sign, exp[2:0], fract[3:0]}; exp == 0 encodes zero
//   seq_state_e : micro-step states of the sequencer
//   BIAS, EXP_MAX, MAX_MAG : format constants
package fpu_pkg;

  localparam int EXP_W   = 3;
  localparam int FRAC_W  = 4;
  localparam int BIAS    = 3;
  localparam int EXP_MAX = 7;
  localparam logic [6:0] MAX_MAG = 7'h7F;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] fract;
  } fp8_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_ALIGN,
    S_OP,
    S_NORM,
    S_ROUND,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/fpu_addsub_seq_if.sv
// fpu_addsub_seq_if: operand/result handshake bundle of the FPU add/sub
// sequencer. Signal suffixes are from the sequencer's point of view.
//   in_valid_i/in_ready_o : operand pair handshake (a_i, b_i, sel_i)
//   out_valid_o/out_ready_i : result handshake (res_o)
//   busy_o  : sequencer is not idle
//   flags_o : {overflow, underflow, inexact}, present only when the
//             FPU_FLAGS_EN macro is defined
// Modports: slave = the sequencer, master = issue logic / writeback side.
interface fpu_addsub_seq_if;
  import fpu_pkg::*;

  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       sel_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] res_o;
  logic       busy_o;
`ifdef FPU_FLAGS_EN
  logic [2:0] flags_o;

  modport slave (
    input  in_valid_i, a_i, b_i, sel_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, busy_o, flags_o
  );

  modport master (
    output in_valid_i, a_i, b_i, sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, busy_o, flags_o
  );
`else
  modport slave (
    input  in_valid_i, a_i, b_i, sel_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, busy_o
  );

  modport master (
    output in_valid_i, a_i, b_i, sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, busy_o
  );
`endif

endinterface

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: combinational round-to-nearest-even.
//   mant_i   : 5-bit mantissa including the hidden bit
//   guard_i, round_i, sticky_i : bits below the mantissa LSB
//   mant_o   : rounded mantissa
//   carry_o  : rounding overflowed the 5-bit mantissa (exponent must +1)
module fpu_round_rne (
  input  logic [4:0] mant_i,
  input  logic       guard_i,
  input  logic       round_i,
  input  logic       sticky_i,
  output logic [4:0] mant_o,
  output logic       carry_o
);

  logic round_up;

  // NOTE: every output of a combinational block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    // Above half rounds up; exactly half rounds to the even mantissa.
    round_up           = guard_i & (round_i | sticky_i | mant_i[0]);
    {carry_o, mant_o}  = {1'b0, mant_i} + {5'd0, round_up};
  end

endmodule

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle 8-bit floating-point add/subtract sequencer.
// One operand pair is accepted in IDLE, then the datapath steps through
// CMP, ALIGN (one shift per cycle), OP, NORM (one shift per cycle), ROUND
// and DONE; the result is offered on a valid/ready handshake.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : fpu_addsub_seq_if.slave (operand, result and status signals)
// Build option: define FPU_FLAGS_EN to add bus.flags_o =
//   {overflow, underflow, inexact}, registered alongside res_o.
module fpu_addsub_seq
  import fpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  fpu_addsub_seq_if.slave bus
);

  seq_state_e state;
  fp8_t       a_q;
  fp8_t       b_q;
  logic       sel_q;
  logic       sign_q;
  logic       eff_sub_q;
  logic [3:0] exp_q;     // extra bit holds exponent 8 after a carry shift
  logic [7:0] l_mant;    // {1, fract, guard, round, sticky}
  logic [7:0] s_mant;
  logic [2:0] d_q;
  logic [8:0] sum_q;     // bit 8 is the add carry
  fp8_t       res_w;     // finished result waiting to be published

  logic       b_eff_sign;
  logic       a_is_l;
  logic       l_sign;
  logic       s_sign;
  logic [2:0] l_exp;
  logic [2:0] s_exp;
  logic [3:0] l_fract;
  logic [3:0] s_fract;
  logic       accept;
  logic       norm_underflow;
  logic [4:0] rnd_mant;
  logic       rnd_carry;
  logic [3:0] exp_rnd;
  logic       res_zero;
  logic       round_overflow;

  always_comb begin
    b_eff_sign = b_q.sign ^ sel_q;
    // Ties go to A so equal magnitudes of opposite sign cancel to +0.
    a_is_l     = {a_q.exp, a_q.fract} >= {b_q.exp, b_q.fract};
    l_sign     = a_is_l ? a_q.sign  : b_eff_sign;
    s_sign     = a_is_l ? b_eff_sign : a_q.sign;
    l_exp      = a_is_l ? a_q.exp   : b_q.exp;
    s_exp      = a_is_l ? b_q.exp   : a_q.exp;
    l_fract    = a_is_l ? a_q.fract : b_q.fract;
    s_fract    = a_is_l ? b_q.fract : a_q.fract;

    accept         = bus.in_valid_i && bus.in_ready_o;
    // A left shift that would take the exponent to 0 flushes to +0.
    norm_underflow = (sum_q != '0) && !sum_q[8] && !sum_q[7] && (exp_q == 4'd1);
    exp_rnd        = exp_q + {3'd0, rnd_carry};
    // A normalized mantissa always has its top bit (or the carry) set, so
    // both clear means NORM left a cancelled or flushed zero behind.
    res_zero       = !(rnd_carry | rnd_mant[4]);
    round_overflow = !res_zero && (exp_rnd > 4'(EXP_MAX));
  end

  fpu_round_rne u_round (
    .mant_i   (sum_q[7:3]),
    .guard_i  (sum_q[2]),
    .round_i  (sum_q[1]),
    .sticky_i (sum_q[0]),
    .mant_o   (rnd_mant),
    .carry_o  (rnd_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: every register is reset, including datapath scratch, so an
      // aborted operation leaves nothing behind.
      state           <= S_IDLE;
      a_q             <= '0;
      b_q             <= '0;
      sel_q           <= 1'b0;
      sign_q          <= 1'b0;
      eff_sub_q       <= 1'b0;
      exp_q           <= '0;
      l_mant          <= '0;
      s_mant          <= '0;
      d_q             <= '0;
      sum_q           <= '0;
      res_w           <= '0;
      bus.in_ready_o  <= 1'b1;
      bus.out_valid_o <= 1'b0;
      bus.res_o       <= '0;
      bus.busy_o      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            a_q            <= bus.a_i;
            b_q            <= bus.b_i;
            sel_q          <= bus.sel_i;
            bus.in_ready_o <= 1'b0;
            bus.busy_o     <= 1'b1;
            state          <= S_CMP;
          end
        end

        S_CMP: begin
          if (a_q.exp == '0 || b_q.exp == '0) begin
            if (b_q.exp != '0)      res_w <= {b_eff_sign, b_q.exp, b_q.fract};
            else if (a_q.exp != '0) res_w <= a_q;
            else                    res_w <= '0;
            state <= S_DONE;
          end else begin
            sign_q    <= l_sign;
            eff_sub_q <= l_sign ^ s_sign;
            exp_q     <= {1'b0, l_exp};
            l_mant    <= {1'b1, l_fract, 3'b000};
            s_mant    <= {1'b1, s_fract, 3'b000};
            d_q       <= l_exp - s_exp;
            state     <= (l_exp != s_exp) ? S_ALIGN : S_OP;
          end
        end

        S_ALIGN: begin
          // The bit falling off the bottom is folded into sticky.
          s_mant <= {1'b0, s_mant[7:2], s_mant[1] | s_mant[0]};
          d_q    <= d_q - 3'd1;
          if (d_q == 3'd1) state <= S_OP;
        end

        S_OP: begin
          // L >= S after alignment, so the difference never goes negative.
          sum_q <= eff_sub_q ? ({1'b0, l_mant} - {1'b0, s_mant})
                             : ({1'b0, l_mant} + {1'b0, s_mant});
          state <= S_NORM;
        end

        S_NORM: begin
          if (sum_q == '0) begin
            state <= S_ROUND;
          end else if (sum_q[8]) begin
            sum_q <= {1'b0, sum_q[8:2], sum_q[1] | sum_q[0]};
            exp_q <= exp_q + 4'd1;
          end else if (!sum_q[7]) begin
            if (norm_underflow) begin
              sum_q <= '0;
              state <= S_ROUND;
            end else begin
              sum_q <= {sum_q[7:0], 1'b0};
              exp_q <= exp_q - 4'd1;
            end
          end else begin
            state <= S_ROUND;
          end
        end

        S_ROUND: begin
          if (res_zero)            res_w <= '0;
          else if (round_overflow) res_w <= {sign_q, MAX_MAG};
          else                     res_w <= {sign_q, exp_rnd[2:0], rnd_mant[3:0]};
          state <= S_DONE;
        end

        S_DONE: begin
          // First DONE cycle publishes the result; later cycles wait for
          // the consumer with res_o frozen.
          if (!bus.out_valid_o) begin
            bus.res_o       <= res_w;
            bus.out_valid_o <= 1'b1;
          end else if (bus.out_ready_i) begin
            bus.out_valid_o <= 1'b0;
            bus.in_ready_o  <= 1'b1;
            bus.busy_o      <= 1'b0;
            state           <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_FLAGS_EN
  logic [2:0] flags_w;   // {overflow, underflow, inexact} of the operation

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_w     <= '0;
      bus.flags_o <= '0;
    end else begin
      unique case (state)
        S_IDLE:  if (accept) flags_w <= '0;
        S_NORM:  if (norm_underflow) flags_w[1] <= 1'b1;
        S_ROUND: begin
          flags_w[2] <= round_overflow;
          flags_w[0] <= |sum_q[2:0];
        end
        S_DONE:  if (!bus.out_valid_o) bus.flags_o <= flags_w;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fpu_addsub_seq.sv
module tb_fpu_addsub_seq;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fpu_addsub_seq_if bus ();

  fpu_addsub_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [7:0] res;
    logic [2:0] flags;
    int         lat;    // 0 = latency not checked
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Operand value in units of 2^-6 (smallest step of exponent 1).
  function automatic int to_units(input logic [7:0] x);
    if (x[6:4] == 3'd0) return 0;
    return (16 + int'(x[3:0])) << (int'(x[6:4]) - 1);
  endfunction

  // Exact integer sum, then round-to-nearest-even back into the format.
  task automatic ref_model(input logic [7:0] a, input logic [7:0] b, input logic sel,
                           output logic [7:0] res, output logic [2:0] flg);
    int   t, mag, sh, m, rem, half, e;
    logic neg, up;
    t   = (a[7] ? -to_units(a) : to_units(a)) +
          ((b[7] ^ sel) ? -to_units(b) : to_units(b));
    neg = (t < 0);
    mag = neg ? -t : t;
    res = 8'h00;
    flg = 3'b000;
    if (mag == 0) return;
    if (mag < 16) begin
      flg = 3'b010;
      return;
    end
    sh = 0;
    while ((mag >> sh) >= 32) sh++;
    m    = mag >> sh;
    rem  = mag - (m << sh);
    half = (sh == 0) ? 0 : (1 << (sh - 1));
    up   = (sh != 0) && ((rem > half) || (rem == half && m[0]));
    flg[0] = (rem != 0);
    m = m + int'(up);
    e = sh + 1;
    if (m == 32) begin
      m = 16;
      e++;
    end
    if (e > 7) begin
      res    = {neg, 7'h7F};
      flg[2] = 1'b1;
    end else begin
      res = {neg, 3'(e), 4'(m)};
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid_o) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sel,
                       input int stall, input logic [7:0] exp_res,
                       input logic [2:0] exp_flags, input int exp_lat);
    int wait_cnt, lat;
    wait_cnt = 0;
    while (!bus.in_ready_o && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (!bus.in_ready_o) check("in_ready_timeout", 32'd0, 32'd1);
    bus.a_i = a;
    bus.b_i = b;
    bus.sel_i = sel;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    wait_valid(lat);
    if (exp_lat != 0) check("latency", lat, exp_lat);
    check("res", bus.res_o, exp_res);
`ifdef FPU_FLAGS_EN
    check("flags", bus.flags_o, exp_flags);
`else
    if (exp_flags == 3'b111) check("flags_unused", 32'd0, 32'd1);
`endif
    repeat (stall) begin
      @(posedge clk); #1;
      check("res_hold", bus.res_o, exp_res);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("valid_drop", bus.out_valid_o, 1'b0);
    check("ready_back", bus.in_ready_o, 1'b1);
  endtask

  vec_t       vecs[13];
  logic [7:0] ra, rb, er;
  logic [2:0] ef;
  logic       rs;
  int         lat;
  logic       seen;

  initial begin
    vecs[0]  = '{8'h30, 8'h30, 1'b0, 8'h40, 3'b000, 6};  // 1+1, carry shift
    vecs[1]  = '{8'h40, 8'h38, 1'b1, 8'h20, 3'b000, 8};  // 2-1.5
    vecs[2]  = '{8'h30, 8'hB0, 1'b1, 8'h40, 3'b000, 6};  // 1-(-1)
    vecs[3]  = '{8'h30, 8'h30, 1'b1, 8'h00, 3'b000, 5};  // 1-1
    vecs[4]  = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 3'b100, 6};  // overflow
    vecs[5]  = '{8'h00, 8'hB8, 1'b1, 8'h38, 3'b000, 2};  // zero fast path
    vecs[6]  = '{8'h30, 8'h11, 1'b0, 8'h34, 3'b001, 7};  // below half
    vecs[7]  = '{8'h30, 8'h12, 1'b0, 8'h34, 3'b001, 7};  // tie, stays even
    vecs[8]  = '{8'h30, 8'h16, 1'b0, 8'h36, 3'b001, 7};  // tie, rounds to even
    vecs[9]  = '{8'h11, 8'h10, 1'b1, 8'h00, 3'b010, 0};  // underflow flush
    vecs[10] = '{8'hB0, 8'h30, 1'b0, 8'h00, 3'b000, 5};  // -1+1
    vecs[11] = '{8'h80, 8'h00, 1'b0, 8'h00, 3'b000, 2};  // both zero
    vecs[12] = '{8'h30, 8'h40, 1'b1, 8'hB0, 3'b000, 7};  // 1-2, B larger

    rst = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.a_i         = 8'h00;
    bus.b_i         = 8'h00;
    bus.sel_i       = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready_o, 1'b1);
    check("rst_out_valid", bus.out_valid_o, 1'b0);
    check("rst_res", bus.res_o, 8'h00);
    check("rst_busy", bus.busy_o, 1'b0);
`ifdef FPU_FLAGS_EN
    check("rst_flags", bus.flags_o, 3'b000);
`endif

    for (int i = 0; i < 13; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].sel, i % 3, vecs[i].res, vecs[i].flags, vecs[i].lat);

    // Backpressure: result frozen, new offers ignored until IDLE.
    bus.a_i = 8'h30; bus.b_i = 8'h30; bus.sel_i = 1'b0; bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    wait_valid(lat);
    bus.a_i = 8'h7F; bus.b_i = 8'h7F; bus.sel_i = 1'b0; bus.in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_res", bus.res_o, 8'h40);
      check("bp_in_ready", bus.in_ready_o, 1'b0);
      check("bp_valid", bus.out_valid_o, 1'b1);
      check("bp_busy", bus.busy_o, 1'b1);
    end
    bus.a_i = 8'h40; bus.b_i = 8'h38; bus.sel_i = 1'b1;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("hs_valid_drop", bus.out_valid_o, 1'b0);
    check("hs_no_overlap", bus.busy_o, 1'b0);
    check("hs_in_ready", bus.in_ready_o, 1'b1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check("hs_next_accept", bus.busy_o, 1'b1);
    wait_valid(lat);
    check("hs_res", bus.res_o, 8'h20);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;

    // Reset while aligning (d = 6) discards the operation.
    bus.a_i = 8'h70; bus.b_i = 8'h10; bus.sel_i = 1'b0; bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", bus.in_ready_o, 1'b1);
    check("mid_rst_busy", bus.busy_o, 1'b0);
    check("mid_rst_valid", bus.out_valid_o, 1'b0);
    check("mid_rst_res", bus.res_o, 8'h00);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) seen = 1'b1;
    end
    check("mid_rst_no_result", seen, 1'b0);

    // Random operands against the exact-arithmetic model.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra[6:4] = 3'd0;
      if ($urandom_range(0, 7) == 0) rb[6:4] = 3'd0;
      rs = 1'($urandom_range(0, 1));
      ref_model(ra, rb, rs, er, ef);
      do_op(ra, rb, rs, $urandom_range(0, 3), er, ef, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
